// File: rtl/phy_rx_pkg.sv
// Shared definitions for the two-lane receive PHY: state codes, control symbols
// and the state-to-output decode used by the link controller.
package phy_rx_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_REL0   = 3'd1,
    ST_REL1   = 3'd2,
    ST_TRAIN  = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  localparam logic [7:0] SYM_COM     = 8'hBC;
  localparam logic [7:0] SYM_IDL     = 8'h7C;
  localparam logic [7:0] COM_SYM_DEF = SYM_COM;

  typedef struct packed {
    logic rst_lane_0;
    logic rst_lane_1;
    logic path_en;
    logic link_up;
  } link_out_t;

  function automatic link_out_t decode_outs(state_e s);
    link_out_t o;
    o = '0;
    case (s)
      ST_REL0:   o.rst_lane_0 = 1'b1;
      ST_REL1,
      ST_TRAIN:  begin o.rst_lane_0 = 1'b1; o.rst_lane_1 = 1'b1; end
      ST_ACTIVE: o = '1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/phy_rx_sat_cnt.sv
// Clearable up-counter with optional saturation and a terminal-count compare.
module phy_rx_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk_2f,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         sat,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk_2f) begin
    if (!reset || clr)              cnt <= '0;
    else if (inc && !(sat && &cnt)) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/phy_rx_link_ctrl.sv
// Link bring-up and supervision for the two-lane receive PHY: staggered lane
// reset release, COM training, lane-valid supervision and retrain on error.
module phy_rx_link_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM_SYM       = COM_SYM_DEF,
  parameter int         STAGGER       = 2,
  parameter int         TRAIN_COUNT   = 4,
  parameter int         TRAIN_TIMEOUT = 64,
  parameter int         MISMATCH_MAX  = 3,
  parameter int         HOLD          = 8
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] lane_0,
  input  logic [7:0] lane_1,
  input  logic       valid_0,
  input  logic       valid_1,
  output logic       rst_lane_0,
  output logic       rst_lane_1,
  output logic       path_en,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] retrain_cnt
);

  localparam int CW = 4;
  localparam int TW = 8;
  localparam int HW = 8;

  state_e    state_q, state_d;
  link_out_t outs_q;
  logic      phase, chg;
  logic      com_match, lane_mis, in_train, in_active, in_hold;
  logic      com_tc, tmo_tc, mis_tc, hs_tc, rc_tc;
  logic [CW-1:0] com_cnt, mis_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [HW-1:0] hs_cnt, hs_last;

  assign com_match = valid_0 & valid_1 & (lane_0 == COM_SYM) & (lane_1 == COM_SYM);
  assign lane_mis  = valid_0 ^ valid_1;
  assign in_train  = (state_q == ST_TRAIN);
  assign in_active = (state_q == ST_ACTIVE);
  assign in_hold   = (state_q == ST_REL0) || (state_q == ST_ERROR);
  // REL0 lasts STAGGER+1 cycles (count 0..STAGGER); ERROR lasts exactly HOLD.
  assign hs_last   = (state_q == ST_REL0) ? HW'(STAGGER) : HW'(HOLD - 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:    state_d = ST_REL0;
      ST_REL0:   if (hs_tc) state_d = ST_REL1;
      ST_REL1:   state_d = ST_TRAIN;
      ST_TRAIN:  if (phase) begin
                   if (com_match && com_tc) state_d = ST_ACTIVE;
                   else if (tmo_tc)         state_d = ST_ERROR;
                 end
      ST_ACTIVE: if (phase && lane_mis && mis_tc) state_d = ST_ERROR;
      ST_ERROR:  if (hs_tc) state_d = ST_REL0;
      default:   state_d = ST_RST;
    endcase
  end

  assign chg = (state_d != state_q);

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      state_q <= ST_RST;
      phase   <= 1'b0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      phase   <= (state_q == ST_RST) ? 1'b0 : ~phase;
      outs_q  <= decode_outs(state_d);
    end
  end

  phy_rx_sat_cnt #(.W(CW)) u_com (
    .clk_2f(clk_2f), .reset(reset),
    .clr(chg | (phase & in_train & ~com_match)),
    .inc(phase & in_train & com_match), .sat(1'b1),
    .last(CW'(TRAIN_COUNT - 1)), .cnt(com_cnt), .tc(com_tc)
  );

  phy_rx_sat_cnt #(.W(TW)) u_tmo (
    .clk_2f(clk_2f), .reset(reset), .clr(chg),
    .inc(phase & in_train), .sat(1'b1),
    .last(TW'(TRAIN_TIMEOUT - 1)), .cnt(tmo_cnt), .tc(tmo_tc)
  );

  phy_rx_sat_cnt #(.W(CW)) u_mis (
    .clk_2f(clk_2f), .reset(reset),
    .clr(chg | (phase & in_active & ~lane_mis)),
    .inc(phase & in_active & lane_mis), .sat(1'b1),
    .last(CW'(MISMATCH_MAX - 1)), .cnt(mis_cnt), .tc(mis_tc)
  );

  phy_rx_sat_cnt #(.W(HW)) u_hs (
    .clk_2f(clk_2f), .reset(reset), .clr(chg),
    .inc(in_hold), .sat(1'b1),
    .last(hs_last), .cnt(hs_cnt), .tc(hs_tc)
  );

  phy_rx_sat_cnt #(.W(8)) u_rc (
    .clk_2f(clk_2f), .reset(reset), .clr(1'b0),
    .inc((state_d == ST_ERROR) && (state_q != ST_ERROR)), .sat(1'b1),
    .last(8'hFF), .cnt(retrain_cnt), .tc(rc_tc)
  );

  // Counter values are only consumed through their terminal-count compares.
  logic unused_cnt;
  assign unused_cnt = ^{com_cnt, mis_cnt, tmo_cnt, hs_cnt, rc_tc};

  assign state      = state_q;
  assign rst_lane_0 = outs_q.rst_lane_0;
  assign rst_lane_1 = outs_q.rst_lane_1;
  assign path_en    = outs_q.path_en;
  assign link_up    = outs_q.link_up;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Scoreboard bench: stimulus queues expected state transitions (cycle, state,
// retrain count); a monitor pops one per observed state change and checks.
module tb_phy_rx_link_ctrl;

  localparam logic [2:0] S_RST = 3'd0, S_REL0 = 3'd1, S_REL1 = 3'd2,
                         S_TRAIN = 3'd3, S_ACT = 3'd4, S_ERR = 3'd5;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic [7:0] rc;
  } exp_t;

  logic       clk_2f = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] lane_0 = 8'hBC, lane_1 = 8'hBC;
  logic       valid_0 = 1'b1, valid_1 = 1'b1;
  logic       rst_lane_0, rst_lane_1, path_en, link_up;
  logic [2:0] state;
  logic [7:0] retrain_cnt;

  phy_rx_link_ctrl dut (
    .clk_2f(clk_2f), .reset(reset),
    .lane_0(lane_0), .lane_1(lane_1), .valid_0(valid_0), .valid_1(valid_1),
    .rst_lane_0(rst_lane_0), .rst_lane_1(rst_lane_1),
    .path_en(path_en), .link_up(link_up),
    .state(state), .retrain_cnt(retrain_cnt)
  );

  initial forever #5 clk_2f = ~clk_2f;

  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   exp_rc = 0;
  exp_t q[$];
  exp_t cur;
  logic mon_en = 1'b0;
  logic [2:0] prev = 3'd7;

  initial forever begin
    @(posedge clk_2f);
    cyc++;
  end

  // Expected {rst_lane_0, rst_lane_1, path_en, link_up, state, retrain_cnt}.
  function automatic logic [14:0] exp_vec(exp_t e);
    logic [3:0] o;
    case (e.st)
      S_REL0:          o = 4'b1000;
      S_REL1, S_TRAIN: o = 4'b1100;
      S_ACT:           o = 4'b1111;
      default:         o = 4'b0000;
    endcase
    return {o, e.st, e.rc};
  endfunction

  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endfunction

  function automatic void push(int at, logic [2:0] st);
    exp_t e;
    e.at = at; e.st = st; e.rc = 8'(exp_rc);
    q.push_back(e);
  endfunction

  function automatic void push_err(int at);
    exp_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
    push(at, S_ERR);
  endfunction

  // Bring-up after REL0 entry at edge r: REL1 at r+3, TRAIN at r+4.
  function automatic int rel(int r);
    push(r, S_REL0);
    push(r + 3, S_REL1);
    push(r + 4, S_TRAIN);
    return r + 4;
  endfunction

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk_2f);
  endtask

  // One lane sample slot = two clk_2f cycles, driven from a negedge.
  task automatic slot(logic v0, logic v1, logic [7:0] l0, logic [7:0] l1);
    valid_0 = v0; valid_1 = v1; lane_0 = l0; lane_1 = l1;
    repeat (2) @(negedge clk_2f);
  endtask

  initial forever begin
    @(negedge clk_2f);
    if (mon_en) begin
      if (state !== prev) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_transition @cycle %0d: state %0d, expected %0d", cyc, state, prev);
        end else begin
          cur = q.pop_front();
          if (cur.at >= 0) check("transition_cycle", cyc, cur.at);
        end
        prev = state;
      end else if (q.size() > 0 && q[0].at >= 0 && q[0].at < cyc) begin
        cur = q.pop_front();
        tests++; fails++;
        $display("FAIL missed_transition @cycle %0d: state %0d, expected %0d at cycle %0d",
                 cyc, state, cur.st, cur.at);
      end
      check("outputs", int'({rst_lane_0, rst_lane_1, path_en, link_up, state, retrain_cnt}),
            int'(exp_vec(cur)));
    end
  end

  initial begin
    int t, a, e;
    logic [7:0] seq1 [8];
    seq1 = '{8'hBC, 8'hBC, 8'hBC, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC};

    // Reset low for 4 cycles, lanes already sending COM.
    push(-1, S_RST);
    @(negedge clk_2f);
    mon_en = 1'b1;
    repeat (3) @(negedge clk_2f);
    reset = 1'b1;
    t = rel(cyc + 1);
    push(t + 8, S_ACT);
    a = t + 8;
    wait_until(a);

    // Two mismatched samples, one matched, then three mismatched.
    push_err(a + 12);
    slot(1, 0, 8'hBC, 8'hBC);
    slot(1, 0, 8'hBC, 8'hBC);
    slot(1, 1, 8'hBC, 8'hBC);
    slot(1, 0, 8'hBC, 8'hBC);
    slot(1, 0, 8'hBC, 8'hBC);
    slot(1, 0, 8'hBC, 8'hBC);
    valid_0 = 1'b1; valid_1 = 1'b1;
    e = a + 12;
    t = rel(e + 8);
    wait_until(t);

    // Broken COM run: needs 8 samples to train.
    push(t + 16, S_ACT);
    for (int i = 0; i < 8; i++) slot(1, 1, 8'hBC, seq1[i]);
    lane_1 = 8'hBC;
    a = t + 16;

    // One-cycle reset pulse in ACTIVE, then full bring-up.
    wait_until(a + 3);
    reset = 1'b0;
    exp_rc = 0;
    push(a + 4, S_RST);
    @(negedge clk_2f);
    reset = 1'b1;
    t = rel(a + 5);
    push(t + 8, S_ACT);
    a = t + 8;
    wait_until(a);

    // Non-COM data: repeated training timeouts until retrain_cnt saturates.
    lane_0 = 8'h55; lane_1 = 8'h55;
    reset = 1'b0;
    exp_rc = 0;
    push(a + 1, S_RST);
    @(negedge clk_2f);
    reset = 1'b1;
    t = rel(a + 2);
    for (int i = 1; i <= 257; i++) begin
      push_err(t + 128);
      t = rel(t + 136);
      wait_until(t);
    end

    // Final reset clears the retrain count.
    wait_until(t + 5);
    reset = 1'b0;
    exp_rc = 0;
    push(cyc + 1, S_RST);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk_2f);
    repeat (2) @(negedge clk_2f);
    check("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
